// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, BCD limits and increment helpers for the clock core
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2
   } mode_t;

   localparam logic [3:0] BCD_MAX            = 4'd9;
   localparam logic [3:0] TENS_MAX           = 4'd5;
   localparam logic [3:0] HR_TENS_MAX        = 4'd2;
   localparam logic [3:0] HR_ONES_MAX_AT_TOP = 4'd3;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   // Returns {carry, next} for a 00..59 field; out-of-range digits fold back to 0.
   function automatic logic [8:0] bcd60_inc(input bcd2_t v);
      bcd2_t r;
      logic  c;
      r = v;
      c = 1'b0;
      if (v.ones >= BCD_MAX) begin
         r.ones = 4'd0;
         if (v.tens >= TENS_MAX) begin
            r.tens = 4'd0;
            c      = 1'b1;
         end else begin
            r.tens = v.tens + 4'd1;
         end
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return {c, r};
   endfunction

   function automatic bcd2_t hr_inc(input bcd2_t v);
      bcd2_t r;
      r = v;
      if ((v.tens >= HR_TENS_MAX) && (v.ones >= HR_ONES_MAX_AT_TOP)) begin
         r = '0;
      end else if (v.ones >= BCD_MAX) begin
         r.ones = 4'd0;
         r.tens = v.tens + 4'd1;
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and press pulse for one button
module btn_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          differ;

   assign differ = sync_q[1] ^ level_q;

   // Level only moves after DEB_CYCLES consecutive cycles away from it; any return restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         press  <= 1'b0;
         if (!differ) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
            press   <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - HH:MM:SS BCD timekeeper with 1 Hz prescaler and MODE/INC set FSM
module clock_time_core
   import clock_pkg::*;
#(
   parameter int TICK_DIV   = 50000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [3:0] digit5,
   output logic [3:0] digit6,
   output logic [5:0] blank,
   output logic [1:0] mode,
   output logic       sec_tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

   logic [PW-1:0] pre_q, pre_d;
   mode_t         state_q, state_d;
   bcd2_t         sec_q, min_q, hr_q;
   bcd2_t         sec_d, min_d, hr_d;
   logic [5:0]    blank_d;
   logic [8:0]    sec_n, min_n;
   logic          mode_press, inc_press;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_mode),
      .press (mode_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_inc),
      .press (inc_press)
   );

   assign sec_tick = (pre_q == PRE_LAST);
   assign sec_n    = bcd60_inc(sec_q);
   assign min_n    = bcd60_inc(min_q);

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      pre_d   = sec_tick ? '0 : pre_q + 1'b1;
      blank_d = 6'b000000;

      case (state_q)
         MODE_RUN: begin
            if (sec_tick) begin
               sec_d = bcd2_t'(sec_n[7:0]);
               if (sec_n[8]) begin
                  min_d = bcd2_t'(min_n[7:0]);
                  if (min_n[8]) begin
                     hr_d = hr_inc(hr_q);
                  end
               end
            end
            if (mode_press) begin
               state_d = MODE_SET_HR;
            end
         end
         MODE_SET_HR: begin
            if (mode_press) begin
               state_d = MODE_SET_MIN;
            end else if (inc_press) begin
               hr_d = hr_inc(hr_q);
            end
         end
         MODE_SET_MIN: begin
            if (mode_press) begin
               // Restart the second so the first tick after leaving set is a full period away.
               state_d = MODE_RUN;
               sec_d   = '0;
               pre_d   = '0;
            end else if (inc_press) begin
               min_d = bcd2_t'(min_n[7:0]);
            end
         end
         default: begin
            state_d = MODE_RUN;
         end
      endcase

      // Blank is registered from next-state values so it lines up with the prescaler it follows.
      case (state_d)
         MODE_SET_HR:  blank_d = (pre_d >= PRE_HALF) ? 6'b110000 : 6'b000000;
         MODE_SET_MIN: blank_d = (pre_d >= PRE_HALF) ? 6'b001100 : 6'b000000;
         default:      blank_d = 6'b000000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q   <= '0;
         state_q <= MODE_RUN;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         blank   <= 6'b000000;
      end else begin
         pre_q   <= pre_d;
         state_q <= state_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         blank   <= blank_d;
      end
   end

   assign digit1 = sec_q.ones;
   assign digit2 = sec_q.tens;
   assign digit3 = min_q.ones;
   assign digit4 = min_q.tens;
   assign digit5 = hr_q.ones;
   assign digit6 = hr_q.tens;
   assign mode   = state_q;

endmodule

// File: tb/tb_clock_time_core.sv
// tb/tb_clock_time_core.sv - directed scoreboard bench for clock_time_core
module tb_clock_time_core;

   logic       clk;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6;
   logic [5:0] blank;
   logic [1:0] mode;
   logic       sec_tick;

   int checks = 0;
   int errors = 0;
   int mh, mm, ms;
   logic [1:0]  mmode;
   logic [25:0] sb_q[$];

   clock_time_core #(.TICK_DIV(10), .DEB_CYCLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .digit1   (digit1),
      .digit2   (digit2),
      .digit3   (digit3),
      .digit4   (digit4),
      .digit5   (digit5),
      .digit6   (digit6),
      .blank    (blank),
      .mode     (mode),
      .sec_tick (sec_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [25:0] model_pack();
      return {mmode, bcd(mh), bcd(mm), bcd(ms)};
   endfunction

   function automatic logic [25:0] dut_pack();
      return {mode, digit6, digit5, digit4, digit3, digit2, digit1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sb_push();
      sb_q.push_back(model_pack());
   endtask

   task automatic sb_check(input string tag);
      logic [25:0] exp;
      exp = sb_q.pop_front();
      check(tag, 32'(dut_pack()), 32'(exp));
   endtask

   task automatic advance_sec();
      ms++;
      if (ms == 60) begin
         ms = 0;
         mm++;
         if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
         end
      end
   endtask

   // Caller is at a negedge; drives a clean press and release.
   task automatic press(input logic pm, input logic pi);
      btn_mode = pm;
      btn_inc  = pi;
      repeat (8) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic press_mode();
      press(1'b1, 1'b0);
      mmode = (mmode == 2'd0) ? 2'd1 : 2'd2;
   endtask

   task automatic press_hr(input int n);
      for (int i = 0; i < n; i++) begin
         press(1'b0, 1'b1);
         mh = (mh + 1) % 24;
      end
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) begin
         press(1'b0, 1'b1);
         mm = (mm + 1) % 60;
      end
   endtask

   // Leaves the caller at the negedge where the last tick is visible.
   task automatic run_ticks(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         k = 0;
         while (sec_tick !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("tick_wait", 32'(k < 20), 32'd1);
         advance_sec();
         if (i < n - 1) @(negedge clk);
      end
   endtask

   task automatic exit_set(input string tag);
      int k;
      btn_mode = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (mode !== 2'd0 && k < 20);
      mmode = 2'd0;
      ms    = 0;
      check({tag, "_mode"}, 32'(mode), 32'd0);
      check({tag, "_sec"}, 32'({digit2, digit1}), 32'd0);
      k = 1;
      while (sec_tick !== 1'b1 && k < 30) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_tick_gap"}, 32'(k), 32'd10);
      advance_sec();
      btn_mode = 1'b0;
      repeat (8) @(negedge clk);
      sb_push();
      sb_check({tag, "_time"});
   endtask

   initial begin
      int pc, k;
      rst      = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      mh = 0; mm = 0; ms = 0; mmode = 2'd0;

      @(negedge clk);
      @(negedge clk);
      sb_push();
      sb_check("reset_time");
      check("reset_blank", 32'(blank), 32'd0);
      check("reset_tick", 32'(sec_tick), 32'd0);

      // Enter SET_HR straight out of reset, before the first tick can land.
      rst = 1'b1;
      press_mode();
      sb_push();
      sb_check("enter_set_hr");

      for (int w = 1; w <= 3; w++) begin
         btn_inc = 1'b1;
         repeat (w) @(negedge clk);
         btn_inc = 1'b0;
         repeat (6) @(negedge clk);
      end
      sb_push();
      sb_check("bounce_reject");

      btn_inc = 1'b1;
      repeat (10) @(negedge clk);
      btn_inc = 1'b0;
      repeat (10) @(negedge clk);
      mh = mh + 1;
      sb_push();
      sb_check("bounce_accept");

      press_hr(22);
      sb_push();
      sb_check("hour_23");
      press_hr(1);
      sb_push();
      sb_check("hour_wrap");
      press_hr(12);
      sb_push();
      sb_check("hour_12");

      press(1'b1, 1'b1);
      mmode = 2'd2;
      sb_push();
      sb_check("simultaneous");

      k = 0;
      while (sec_tick !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("blink_sync", 32'(k < 20), 32'd1);
      pc = 9;
      for (int i = 0; i < 20; i++) begin
         check("blink", 32'(blank), (pc >= 5) ? 32'h0c : 32'h00);
         @(negedge clk);
         pc = (pc + 1) % 10;
      end

      press_min(34);
      sb_push();
      sb_check("min_34");

      exit_set("exit_a");
      run_ticks(55);
      @(negedge clk);
      sb_push();
      sb_check("time_123456");

      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_digits", 32'({digit6, digit5, digit4, digit3, digit2, digit1}), 32'd0);
      check("async_rst_mode", 32'(mode), 32'd0);
      check("async_rst_blank", 32'(blank), 32'd0);
      check("async_rst_tick", 32'(sec_tick), 32'd0);
      mh = 0; mm = 0; ms = 0; mmode = 2'd0;

      @(negedge clk);
      rst = 1'b1;
      press_mode();
      press_hr(23);
      press_mode();
      press_min(59);
      sb_push();
      sb_check("set_2359");
      exit_set("exit_b");
      run_ticks(58);
      @(negedge clk);
      sb_push();
      sb_check("time_235959");
      run_ticks(1);
      @(negedge clk);
      sb_push();
      sb_check("rollover");

      run_ticks(42);
      press_mode();
      sb_push();
      sb_check("freeze_hr_42");
      press_mode();
      repeat (30) @(negedge clk);
      sb_push();
      sb_check("freeze_min_42");
      exit_set("exit_c");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
